// File: rtl/cla_pkg.sv
// Shared carry-look-ahead helpers for the 4-bit adder and subtractor slices.
// cla4_sum expands the carries from generate/propagate terms instead of rippling them.
package cla_pkg;

  localparam int SLICE_W = 4;

  typedef struct packed {
    logic [SLICE_W-1:0] g;
    logic [SLICE_W-1:0] p;
  } slice_gp_t;

  typedef struct packed {
    logic               cout;
    logic [SLICE_W-1:0] sum;
  } slice_res_t;

  function automatic slice_res_t cla4_sum(input logic [SLICE_W-1:0] a,
                                          input logic [SLICE_W-1:0] b,
                                          input logic               cin);
    slice_gp_t        gp;
    logic [SLICE_W:0] c;
    slice_res_t       r;
    gp.g = a & b;
    gp.p = a ^ b;
    c[0] = cin;
    c[1] = gp.g[0] | (gp.p[0] & cin);
    c[2] = gp.g[1] | (gp.p[1] & gp.g[0]) | (gp.p[1] & gp.p[0] & cin);
    c[3] = gp.g[2] | (gp.p[2] & gp.g[1]) | (gp.p[2] & gp.p[1] & gp.g[0])
         | (gp.p[2] & gp.p[1] & gp.p[0] & cin);
    c[4] = gp.g[3] | (gp.p[3] & gp.g[2]) | (gp.p[3] & gp.p[2] & gp.g[1])
         | (gp.p[3] & gp.p[2] & gp.p[1] & gp.g[0])
         | (gp.p[3] & gp.p[2] & gp.p[1] & gp.p[0] & cin);
    r.sum  = gp.p ^ c[SLICE_W-1:0];
    r.cout = c[SLICE_W];
    return r;
  endfunction

endpackage

// File: rtl/cla4_slice.sv
// Combinational 4-bit carry-look-ahead slice; zero latency, no flow control.
module cla4_slice
  import cla_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);

  assign {cout, sum} = cla4_sum(a, b, cin);

endmodule

// File: rtl/cla_pipe_subtractor.sv
// Pipelined a - b - bin, one CLA slice per register stage; latency STAGES cycles.
// Backpressure stalls the whole pipe when the output is held (in_ready = out_ready || !out_valid).
module cla_pipe_subtractor
  import cla_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = SLICE_W
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int STAGES = WIDTH / SLICE;

  logic advance;
  logic ovf_q;

  assign advance  = out_ready || !out_valid;
  assign in_ready = advance;

  genvar k;
  for (k = 0; k < STAGES; k++) begin : g_stage
    // src_a/src_b shrink by one slice per stage: only unconsumed operand bits travel on
    logic [WIDTH-SLICE*k-1:0] src_a;
    logic [WIDTH-SLICE*k-1:0] src_b;
    logic [WIDTH-1:0]         src_d;
    logic                     src_v;
    logic                     src_bw;
    logic [WIDTH-1:0]         nxt_d;
    logic [SLICE-1:0]         sum;
    logic                     cout;
    logic                     vld_q;
    logic [WIDTH-1:0]         dif_q;
    logic                     bw_q;

    if (k == 0) begin : g_head
      assign src_v  = in_valid;
      assign src_a  = a;
      assign src_b  = b;
      assign src_d  = '0;
      assign src_bw = bin;
    end else begin : g_body
      assign src_v  = g_stage[k-1].vld_q;
      assign src_a  = g_stage[k-1].g_carry.a_q;
      assign src_b  = g_stage[k-1].g_carry.b_q;
      assign src_d  = g_stage[k-1].dif_q;
      assign src_bw = g_stage[k-1].bw_q;
    end

    // subtraction as a + ~b + ~borrow
    cla4_slice u_slice (
      .a    (src_a[SLICE-1:0]),
      .b    (~src_b[SLICE-1:0]),
      .cin  (~src_bw),
      .sum  (sum),
      .cout (cout)
    );

    always_comb begin
      nxt_d                    = src_d;
      nxt_d[k*SLICE +: SLICE]  = sum;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_q <= 1'b0;
        dif_q <= '0;
        bw_q  <= 1'b0;
      end else if (advance) begin
        vld_q <= src_v;
        dif_q <= nxt_d;
        bw_q  <= ~cout;
      end
    end

    if (k < STAGES - 1) begin : g_carry
      logic [WIDTH-SLICE*(k+1)-1:0] a_q;
      logic [WIDTH-SLICE*(k+1)-1:0] b_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (advance) begin
          a_q <= src_a[WIDTH-SLICE*k-1:SLICE];
          b_q <= src_b[WIDTH-SLICE*k-1:SLICE];
        end
      end
    end else begin : g_tail
      // the top slice still sees the operand sign bits, so overflow is resolved here
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (advance) begin
          ovf_q <= (src_a[SLICE-1] != src_b[SLICE-1]) && (sum[SLICE-1] != src_a[SLICE-1]);
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].vld_q;
  assign diff      = g_stage[STAGES-1].dif_q;
  assign bout      = g_stage[STAGES-1].bw_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_cla_pipe_subtractor.sv
// Randomized and directed bench for cla_pipe_subtractor against an arithmetic reference model.
module tb_cla_pipe_subtractor;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [17:0] exp_q[$];
  logic [17:0] sb_e;

  always #5 clk = ~clk;

  cla_pipe_subtractor #(.WIDTH(WIDTH), .SLICE(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // {ovf, bout, diff} from integer arithmetic on the operands
  function automatic logic [17:0] ref_sub(input logic [15:0] x, input logic [15:0] y,
                                          input logic bi);
    int          ud;
    int          sd;
    logic [15:0] d;
    logic        bo;
    logic        ov;
    ud = int'(x) - int'(y) - int'(bi);
    sd = int'($signed(x)) - int'($signed(y)) - int'(bi);
    d  = ud[15:0];
    bo = (ud < 0);
    ov = (sd > 32767) || (sd < -32768);
    return {ov, bo, d};
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_token", 32'd1, 32'd0);
        end else begin
          sb_e = exp_q.pop_front();
          chk("sb_diff", 32'(diff), 32'(sb_e[15:0]));
          chk("sb_bout", 32'(bout), 32'(sb_e[16]));
          chk("sb_ovf",  32'(ovf),  32'(sb_e[17]));
        end
      end
      if (in_valid && in_ready) exp_q.push_back(ref_sub(a, b, bin));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] x, input logic [15:0] y,
                       input logic bi);
    in_valid = v;
    a        = x;
    b        = y;
    bin      = bi;
  endtask

  task automatic drive_rand(input logic v);
    drive(v, 16'($urandom()), 16'($urandom()), 1'($urandom()));
  endtask

  task automatic run_single(input string tag, input logic [15:0] x, input logic [15:0] y,
                            input logic bi, input logic [15:0] ed, input logic eb,
                            input logic eo);
    int lat;
    lat       = 0;
    out_ready = 1'b1;
    drive(1'b1, x, y, bi);
    @(negedge clk);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    for (int c = 1; c <= 8 && lat == 0; c++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = c;
        chk({tag, "_diff"}, 32'(diff), 32'(ed));
        chk({tag, "_bout"}, 32'(bout), 32'(eb));
        chk({tag, "_ovf"},  32'(ovf),  32'(eo));
      end
    end
    chk({tag, "_latency"}, 32'(lat), 32'd4);
    tick();
  endtask

  // out_valid must replay the in_valid pattern four cycles later
  task automatic run_pattern(input string tag, input int n, input logic [31:0] pat);
    logic ev;
    out_ready = 1'b1;
    for (int j = 0; j < n + 7; j++) begin
      drive_rand((j < n) ? pat[j] : 1'b0);
      @(negedge clk);
      ev = (j >= 4 && j - 4 < n) ? pat[j-4] : 1'b0;
      chk(tag, 32'(out_valid), 32'(ev));
      tick();
    end
    chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic run_backpressure();
    logic [17:0] held;
    held      = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive_rand(1'b1);
      tick();
    end
    out_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      drive_rand(1'b1);
      @(negedge clk);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      if (s == 0) held = {ovf, bout, diff};
      else chk("bp_hold", 32'({ovf, bout, diff}), 32'(held));
      tick();
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(negedge clk);
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    repeat (8) tick();
    chk("bp_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic run_reset_midflight();
    out_ready = 1'b0;
    drive(1'b1, 16'h7FFF, 16'hFFFF, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive_rand(1'b1);
      tick();
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("rmf_pre_valid", 32'(out_valid), 32'd1);
    chk("rmf_pre_diff", 32'(diff), 32'h8000);
    #2 rst = 1'b1;
    #1;
    chk("rmf_out_valid", 32'(out_valid), 32'd0);
    chk("rmf_diff", 32'(diff), 32'd0);
    chk("rmf_bout", 32'(bout), 32'd0);
    chk("rmf_ovf", 32'(ovf), 32'd0);
    chk("rmf_in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    out_ready = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rmf_no_stale", 32'(out_valid), 32'd0);
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected run to finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, '0, '0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_bout", 32'(bout), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    #2 rst = 1'b0;
    tick();

    run_single("s_4m7",     16'd4,     16'd7,     1'b0, 16'hFFFD, 1'b1, 1'b0);
    run_single("s_5m2",     16'd5,     16'd2,     1'b0, 16'h0003, 1'b0, 1'b0);
    run_single("s_8m5b",    16'd8,     16'd5,     1'b1, 16'h0002, 1'b0, 1'b0);
    run_single("s_ovf_neg", 16'h8000,  16'h0001,  1'b0, 16'h7FFF, 1'b0, 1'b1);
    run_single("s_ovf_pos", 16'h7FFF,  16'hFFFF,  1'b0, 16'h8000, 1'b1, 1'b1);

    run_pattern("b2b_valid", 16, 32'h0000_FFFF);
    run_pattern("bubble_valid", 8, 32'h0000_0055);
    run_backpressure();
    run_reset_midflight();
    run_single("s_after_rst", 16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0);

    repeat (4) tick();
    chk("final_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
